arithmetic_logic_unit: RTL and testbench

ARITHMETIC_LOGIC_UNIT -- requirements
Module: arithmetic_logic_unit

---
 rtl/arithmetic_logic_unit_if.sv | 24 ++
 rtl/arithmetic_logic_unit.sv | 113 +++++++++++
 tb/tb_arithmetic_logic_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/arithmetic_logic_unit_if.sv
// Operand/result bundle for the data-processing ALU.
// Signals: a, b (operands), cpsr (NZCV source), opcode (operation select),
//          result, flags (new NZCV), wb (destination write-back enable).
interface arithmetic_logic_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] cpsr;
  logic [3:0]  opcode;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        wb;

  // Issuer drives operands and samples results.
  modport master (
    output a, b, cpsr, opcode,
    input  result, flags, wb
  );

  // ALU consumes operands and drives registered results.
  modport slave (
    input  a, b, cpsr, opcode,
    output result, flags, wb
  );
endinterface

// File: rtl/arithmetic_logic_unit.sv
// ARM-style data-processing ALU: 16 opcodes, NZCV generation, write-back flag.
// Latency: 1 cycle (outputs registered); accepts a new operation every cycle.
// Backpressure: none; there is no handshake, every edge captures a result.
// Ports: clk, reset (sync active-high), alu.slave (a, b, cpsr, opcode in;
//        result, flags, wb out).
module arithmetic_logic_unit (
  input  logic                    clk,
  input  logic                    reset,
  arithmetic_logic_unit_if.slave  alu
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  logic [31:0] result_d, result_q;
  logic [3:0]  flags_d,  flags_q;
  logic        wb_d,     wb_q;

  logic        c_in;
  logic        is_arith;
  logic        is_sub;
  logic        arith_cin;
  logic [31:0] x_op;
  logic [31:0] y_op;
  logic [31:0] y_eff;
  logic [32:0] sum33;
  logic        c_out;
  logic        v_out;

  assign c_in = alu.cpsr[29];

  always_comb begin
    is_arith  = 1'b0;
    is_sub    = 1'b0;
    arith_cin = 1'b0;
    x_op      = alu.a;
    y_op      = alu.b;
    unique case (alu.opcode)
      OP_ADD, OP_CMN: begin is_arith = 1'b1; end
      OP_ADC:         begin is_arith = 1'b1; arith_cin = c_in; end
      OP_SUB, OP_CMP: begin is_arith = 1'b1; is_sub = 1'b1; arith_cin = 1'b1; end
      OP_SBC:         begin is_arith = 1'b1; is_sub = 1'b1; arith_cin = c_in; end
      OP_RSB: begin
        is_arith = 1'b1; is_sub = 1'b1; arith_cin = 1'b1;
        x_op = alu.b; y_op = alu.a;
      end
      OP_RSC: begin
        is_arith = 1'b1; is_sub = 1'b1; arith_cin = c_in;
        x_op = alu.b; y_op = alu.a;
      end
      default: begin end
    endcase
  end

  // Subtraction is x + ~y + cin, so the 33rd bit is directly NOT-borrow.
  assign y_eff = is_sub ? ~y_op : y_op;
  assign sum33 = {1'b0, x_op} + {1'b0, y_eff} + {32'd0, arith_cin};
  assign c_out = sum33[32];
  // Overflow: effective operands agree in sign but the sum's sign differs.
  assign v_out = (x_op[31] == y_eff[31]) && (sum33[31] != x_op[31]);

  always_comb begin
    result_d = 32'd0;
    unique case (alu.opcode)
      OP_AND, OP_TST: result_d = alu.a & alu.b;
      OP_EOR, OP_TEQ: result_d = alu.a ^ alu.b;
      OP_ORR:         result_d = alu.a | alu.b;
      OP_MOV:         result_d = alu.b;
      OP_BIC:         result_d = alu.a & ~alu.b;
      OP_MVN:         result_d = ~alu.b;
      default:        result_d = sum33[31:0];
    endcase

    flags_d[3] = result_d[31];
    flags_d[2] = (result_d == 32'd0);
    // Logical ops leave C and V as they were.
    flags_d[1] = is_arith ? c_out : alu.cpsr[29];
    flags_d[0] = is_arith ? v_out : alu.cpsr[28];

    wb_d = !(alu.opcode inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 32'd0;
      flags_q  <= 4'b0000;
      wb_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      wb_q     <= wb_d;
    end
  end

  assign alu.result = result_q;
  assign alu.flags  = flags_q;
  assign alu.wb     = wb_q;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed-vector bench: stimulus pushes expected results into a queue,
// a monitor pops one entry per captured edge and compares all outputs.
module tb_arithmetic_logic_unit;

  logic clk;
  logic reset;

  arithmetic_logic_unit_if alu_if ();

  arithmetic_logic_unit dut (
    .clk   (clk),
    .reset (reset),
    .alu   (alu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        wb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] AND_ = 4'd0,  EOR_ = 4'd1,  SUB_ = 4'd2,  RSB_ = 4'd3;
  localparam logic [3:0] ADD_ = 4'd4,  ADC_ = 4'd5,  SBC_ = 4'd6,  RSC_ = 4'd7;
  localparam logic [3:0] TST_ = 4'd8,  TEQ_ = 4'd9,  CMP_ = 4'd10, CMN_ = 4'd11;
  localparam logic [3:0] ORR_ = 4'd12, MOV_ = 4'd13, BIC_ = 4'd14, MVN_ = 4'd15;

  task automatic issue(input string name, input logic rst, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] cpsr, input logic [31:0] er,
                       input logic [3:0] ef, input logic ew);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    alu_if.opcode = op;
    alu_if.a      = a;
    alu_if.b      = b;
    alu_if.cpsr   = cpsr;
    e.name = name; e.res = er; e.flg = ef; e.wb = ew;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (alu_if.result !== e.res) begin
          errors++;
          $display("FAIL %s result: got %h expected %h", e.name, alu_if.result, e.res);
        end
        checks++;
        if (alu_if.flags !== e.flg) begin
          errors++;
          $display("FAIL %s flags: got %b expected %b", e.name, alu_if.flags, e.flg);
        end
        checks++;
        if (alu_if.wb !== e.wb) begin
          errors++;
          $display("FAIL %s wb: got %b expected %b", e.name, alu_if.wb, e.wb);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    alu_if.opcode = ADD_;
    alu_if.a = 32'd0;
    alu_if.b = 32'd0;
    alu_if.cpsr = 32'd0;

    issue("reset0",   1, ADD_, 32'd1,        32'd1,        32'h0,        32'h0,        4'b0000, 0);
    issue("reset1",   1, MVN_, 32'd0,        32'd0,        32'hF000_0000, 32'h0,       4'b0000, 0);
    issue("add_wrap", 0, ADD_, 32'hFFFF_FFFF, 32'd1,       32'h0,        32'h0,        4'b0110, 1);
    issue("add_ovf",  0, ADD_, 32'h7FFF_FFFF, 32'd1,       32'h0,        32'h8000_0000, 4'b1001, 1);
    issue("cmp_lt",   0, CMP_, 32'd3,        32'd5,        32'h0,        32'hFFFF_FFFE, 4'b1000, 0);
    issue("cmp_eq",   0, CMP_, 32'd5,        32'd5,        32'h0,        32'h0,        4'b0110, 0);
    issue("adc_c1",   0, ADC_, 32'd1,        32'd2,        32'h2000_0000, 32'd4,       4'b0000, 1);
    issue("sbc_c0",   0, SBC_, 32'd5,        32'd2,        32'h0,        32'd2,        4'b0010, 1);
    issue("mvn_cv",   0, MVN_, 32'h0,        32'h0,        32'h3000_0000, 32'hFFFF_FFFF, 4'b1011, 1);
    issue("bic",      0, BIC_, 32'hFF,       32'h0F,       32'h0,        32'hF0,       4'b0000, 1);
    // Back-to-back ADDs with reset pulsed in the middle.
    issue("add_b2b",  0, ADD_, 32'd10,       32'd20,       32'h0,        32'd30,       4'b0000, 1);
    issue("add_rst",  1, ADD_, 32'd7,        32'd8,        32'h0,        32'h0,        4'b0000, 0);
    issue("add_rel",  0, ADD_, 32'd2,        32'd3,        32'h0,        32'd5,        4'b0000, 1);
    issue("rsb",      0, RSB_, 32'd5,        32'd3,        32'h0,        32'hFFFF_FFFE, 4'b1000, 1);
    issue("rsc_c0",   0, RSC_, 32'd1,        32'd1,        32'h0,        32'hFFFF_FFFF, 4'b1000, 1);
    issue("tst",      0, TST_, 32'hF0,       32'h0F,       32'h2000_0000, 32'h0,       4'b0110, 0);
    issue("teq",      0, TEQ_, 32'h8000_0000, 32'h0,       32'h1000_0000, 32'h8000_0000, 4'b1001, 0);
    issue("cmn",      0, CMN_, 32'h8000_0000, 32'h8000_0000, 32'h0,      32'h0,        4'b0111, 0);
    issue("and",      0, AND_, 32'hFFFF_0000, 32'h0FF0_FF00, 32'h0,      32'h0FF0_0000, 4'b0000, 1);
    issue("eor",      0, EOR_, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0,      32'h5555_5555, 4'b0000, 1);
    issue("orr",      0, ORR_, 32'hF0,       32'h0F,       32'h0,        32'hFF,       4'b0000, 1);
    issue("mov_zero", 0, MOV_, 32'h1234,     32'h0,        32'h0,        32'h0,        4'b0100, 1);
    issue("sub_ovf",  0, SUB_, 32'h8000_0000, 32'd1,       32'h0,        32'h7FFF_FFFF, 4'b0011, 1);
    issue("sbc_c1",   0, SBC_, 32'd0,        32'd0,        32'h2000_0000, 32'h0,       4'b0110, 1);
    issue("adc_wrap", 0, ADC_, 32'hFFFF_FFFF, 32'd0,       32'h2000_0000, 32'h0,       4'b0110, 1);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
